// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the single synchronous-read
// memory of the multicycle core. Port 0 (CPU datapath) has fixed priority.
// Port 1 (loader/debug) is forced through after MAX_WAIT lost arbitrations.
// Each transaction occupies two cycles: ACCESS (gnt + memory strobe), then
// RESPOND (done + read data).
// Optional build macro MEM_ARB_STATS_EN adds saturating 16-bit per-port
// grant counters on ports stat_gnt0 / stat_gnt1.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t            state;
    logic              owner;      // 0 = port 0, 1 = port 1
    logic              owner_we;   // latched direction of the in-flight access
    logic [CNT_W-1:0]  wait_cnt;   // consecutive arbitrations port 1 has lost
    logic [DATA_W-1:0] rdata_q0;
    logic [DATA_W-1:0] rdata_q1;

    logic any_req;
    logic pick1;
    logic resp_read;

    // Arbitration decision: port 0 wins ties unless port 1 has starved long enough
    always_comb begin
        // NOTE: every always_comb output gets a value on entry, so no path can infer a latch.
        any_req   = p0_req | p1_req;
        pick1     = p1_req & (~p0_req | (wait_cnt == WAIT_LIMIT));
        resp_read = (state == RESPOND) & ~owner_we;
    end

    // Main FSM with registered grant/done/memory strobes and starvation counter
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            owner_we  <= 1'b0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
        end else begin
            // Pulses default low; only the cycle that needs them raises them.
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;

            case (state)
                IDLE, RESPOND: begin
                    if (any_req) begin
                        state  <= ACCESS;
                        busy   <= 1'b1;
                        owner  <= pick1;
                        mem_en <= 1'b1;
                        if (pick1) begin
                            owner_we  <= p1_we;
                            mem_we    <= p1_we;
                            mem_addr  <= p1_addr;
                            mem_wdata <= p1_wdata;
                            p1_gnt    <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            owner_we  <= p0_we;
                            mem_we    <= p0_we;
                            mem_addr  <= p0_addr;
                            mem_wdata <= p0_wdata;
                            p0_gnt    <= 1'b1;
                            if (p1_req && (wait_cnt != WAIT_LIMIT))
                                wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                ACCESS: begin
                    state <= RESPOND;
                    busy  <= 1'b1;
                    if (owner) p1_done <= 1'b1;
                    else       p0_done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Hold the owner's read data after its done pulse, until its next read completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q0 <= '0;
            rdata_q1 <= '0;
        end else if (resp_read) begin
            if (owner) rdata_q1 <= mem_rdata;
            else       rdata_q0 <= mem_rdata;
        end
    end

    // Memory data arrives during RESPOND, so pass it through in that cycle
    // to make it valid alongside done; the holding register covers later cycles.
    always_comb begin
        p0_rdata = rdata_q0;
        p1_rdata = rdata_q1;
        if (resp_read) begin
            if (owner) p1_rdata = mem_rdata;
            else       p0_rdata = mem_rdata;
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating per-port grant counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
        end else begin
            if (p0_gnt && (stat_gnt0 != 16'hFFFF)) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (p1_gnt && (stat_gnt1 != 16'hFFFF)) stat_gnt1 <= stat_gnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter with a
// transaction-level reference (arbitration rule + reference memory).
// Build with MEM_ARB_STATS_EN defined to also check the grant counters.
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_done, p1_gnt, p1_done;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]       stat_gnt0, stat_gnt1;
`endif

    int checks = 0;
    int errors = 0;

    // Environment memory (driven by the DUT) and reference memory (driven by the model)
    logic [DATA_W-1:0] env_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_wait;
    int                ref_gnt [2];
    logic [DATA_W-1:0] ref_rdata [2];
    int                win_q [$];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr[5:0]] = mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[5:0]];
        end
    end

    // Cycle-level protocol invariants
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((mem_we && !mem_en) || (p0_gnt && p1_gnt) || (p0_done && p1_done)) begin
                errors++;
                $display("FAIL protocol we=%b en=%b gnt=%b%b done=%b%b (need we<=en, one-hot)",
                         mem_we, mem_en, p1_gnt, p0_gnt, p1_done, p0_done);
            end
        end
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference arbitration: decides the winner from the request pair and starvation count
    function automatic int ref_pick(input logic r0, input logic r1);
        if (r0 && r1) begin
            if (ref_wait == MAX_WAIT) begin
                ref_wait = 0;
                return 1;
            end
            ref_wait = (ref_wait < MAX_WAIT) ? ref_wait + 1 : MAX_WAIT;
            return 0;
        end
        if (r1) begin
            ref_wait = 0;
            return 1;
        end
        return 0;
    endfunction

    function automatic void clear_ref();
        ref_wait     = 0;
        ref_gnt[0]   = 0;
        ref_gnt[1]   = 0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endfunction

    task automatic raise(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic random_reqs();
        if (!p0_req && $urandom_range(0, 99) < 60)
            raise(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)), $urandom());
        if (!p1_req && $urandom_range(0, 99) < 60)
            raise(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)), $urandom());
    endtask

    // One arbitration opportunity: either an idle cycle or a full two-cycle transaction
    task automatic step();
        int                w;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        exp_pulse;
        if (!p0_req && !p1_req) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, mem_en, p1_gnt, p0_gnt} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_outputs got %b exp 0000", {busy, mem_en, p1_gnt, p0_gnt});
            end
            return;
        end
        w         = ref_pick(p0_req, p1_req);
        we        = (w == 1) ? p1_we    : p0_we;
        addr      = (w == 1) ? p1_addr  : p0_addr;
        wdata     = (w == 1) ? p1_wdata : p0_wdata;
        exp_pulse = (w == 1) ? 2'b10 : 2'b01;

        @(posedge clk); #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== exp_pulse) begin
            errors++;
            $display("FAIL access_gnt got %b exp %b", {p1_gnt, p0_gnt}, exp_pulse);
        end
        checks++;
        if ({busy, mem_en, mem_we} !== {2'b11, we}) begin
            errors++;
            $display("FAIL access_strobes busy/en/we got %b exp %b", {busy, mem_en, mem_we}, {2'b11, we});
        end
        checks++;
        if (mem_addr !== addr) begin
            errors++;
            $display("FAIL access_addr got %h exp %h", mem_addr, addr);
        end
        if (we) begin
            checks++;
            if (mem_wdata !== wdata) begin
                errors++;
                $display("FAIL access_wdata got %h exp %h", mem_wdata, wdata);
            end
            ref_mem[addr[5:0]] = wdata;
        end else begin
            ref_rdata[w] = ref_mem[addr[5:0]];
        end
        ref_gnt[w]++;
        win_q.push_back(w);
        if (w == 1) p1_req = 1'b0;
        else        p0_req = 1'b0;

        @(posedge clk); #1;
        checks++;
        if ({p1_done, p0_done} !== exp_pulse) begin
            errors++;
            $display("FAIL respond_done got %b exp %b", {p1_done, p0_done}, exp_pulse);
        end
        checks++;
        if ({busy, mem_en, p1_gnt, p0_gnt} !== 4'b1000) begin
            errors++;
            $display("FAIL respond_outputs got %b exp 1000", {busy, mem_en, p1_gnt, p0_gnt});
        end
        checks++;
        if (p0_rdata !== ref_rdata[0] || p1_rdata !== ref_rdata[1]) begin
            errors++;
            $display("FAIL respond_rdata got %h/%h exp %h/%h", p0_rdata, p1_rdata, ref_rdata[0], ref_rdata[1]);
        end
    endtask

    task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
        checks++;
        if (stat_gnt0 !== 16'(ref_gnt[0]) || stat_gnt1 !== 16'(ref_gnt[1])) begin
            errors++;
            $display("FAIL stats got %0d/%0d exp %0d/%0d", stat_gnt0, stat_gnt1, ref_gnt[0], ref_gnt[1]);
        end
`endif
    endtask

    task automatic test_reset();
        p0_req = 1'b0; p1_req = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, mem_en, mem_we, p0_gnt, p1_gnt, p0_done, p1_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {busy, mem_en, mem_we, p0_gnt, p1_gnt, p0_done, p1_done});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h exp all 0",
                     mem_addr, mem_wdata, p0_rdata, p1_rdata);
        end
        clear_ref();
        check_stats();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
    endtask

    task automatic test_directed();
        env_mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        raise(0, 1'b0, 32'h10, '0);
        step();
        checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL directed_read got %h exp deadbeef", p0_rdata);
        end
        raise(1, 1'b1, 32'h20, 32'h00001234);
        step();
        checks++;
        if (env_mem[32] !== 32'h00001234) begin
            errors++;
            $display("FAIL directed_write mem[0x20]=%h exp 00001234", env_mem[32]);
        end
    endtask

    task automatic test_starvation();
        test_reset();
        win_q.delete();
        for (int i = 0; i < 10; i++) begin
            if (!p0_req) raise(0, 1'b0, 32'($urandom_range(0, DEPTH - 1)), '0);
            if (!p1_req) raise(1, 1'b0, 32'($urandom_range(0, DEPTH - 1)), '0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (win_q[i] !== ((i % 5 == 4) ? 1 : 0)) begin
                errors++;
                $display("FAIL starve_order grant %0d got port %0d exp port %0d", i, win_q[i], (i % 5 == 4) ? 1 : 0);
            end
        end
`ifdef MEM_ARB_STATS_EN
        checks++;
        if (stat_gnt0 !== 16'd8 || stat_gnt1 !== 16'd2) begin
            errors++;
            $display("FAIL starve_stats got %0d/%0d exp 8/2", stat_gnt0, stat_gnt1);
        end
`endif
        p0_req = 1'b0; p1_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int i = 0; i < 3; i++) begin
            raise(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)), $urandom());
            step();
        end
        step();
        check_stats();
    endtask

    task automatic test_reset_mid();
        raise(0, 1'b0, 32'($urandom_range(0, DEPTH - 1)), '0);
        @(posedge clk); #1;
        checks++;
        if ({p0_gnt, mem_en, busy} !== 3'b111) begin
            errors++;
            $display("FAIL midrst_access got %b exp 111", {p0_gnt, mem_en, busy});
        end
        p0_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({p0_gnt, mem_en, mem_we, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async got %b exp 0000", {p0_gnt, mem_en, mem_we, busy});
        end
        clear_ref();
        @(posedge clk); #1;
        checks++;
        if ({p0_done, p1_done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_nodone got %b exp 000", {p0_done, p1_done, busy});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, p0_done, p0_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL midrst_release busy=%b done=%b rd=%h exp 0/0/0", busy, p0_done, p0_rdata);
        end
        check_stats();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            random_reqs();
            step();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step();
        check_stats();
    endtask

    initial begin
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = $urandom();
            ref_mem[i] = env_mem[i];
        end
        test_reset();
        test_directed();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
